ext_ahb_mailbox_slave: RTL

//  AHB-Lite responder on the SoC external slave port (custom window 0x8001_0000, 64 KB).

---
 rtl/ext_ahb_mailbox_slave.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ext_ahb_mailbox_slave.sv
// AHB-Lite responder exposing a word FIFO mailbox, a checksum of popped words
// and a programmable number of wait states per data phase.
module ext_ahb_mailbox_slave #(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned PTR_W    = 4,
   parameter int unsigned WAIT_RST = 0
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic        HREADY,
   input  logic [15:0] HADDR,
   input  logic        HWRITE,
   input  logic [3:0]  HSIZE,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        IRQ
);

   typedef enum logic [1:0] {ST_IDLE, ST_STALL, ST_RESP} state_t;

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [4:0]       addr_q;
   logic             write_q;
   logic [1:0]       size_q;

   logic             en_q;
   logic [3:0]       wait_q;
   logic             ovf_q, unf_q;
   logic [31:0]      sum_q;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic [31:0]      mem [DEPTH];

   logic             accept, resp, wr, rd;
   logic [2:0]       reg_idx;
   logic [3:0]       lane;
   logic [31:0]      wmask, wbits;
   logic             empty, full;
   logic             wr_ctrl, wr_stat, wr_sum, wr_wait, clr;
   logic             push_req, pop_req, do_push, do_pop;
   logic [31:0]      head, rdata;
   logic             unused_bits;

   assign unused_bits = &{1'b0, HSIZE[3:2], HADDR[15:5]};

   // Address phase is only sampled outside STALL so a stalled transfer keeps its address.
   assign accept  = HSEL & HREADY & (state_q != ST_STALL);
   assign resp    = (state_q == ST_RESP);
   assign wr      = resp & write_q;
   assign rd      = resp & ~write_q;
   assign reg_idx = addr_q[4:2];
   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_CNT);
   assign head    = mem[rd_ptr_q];

   assign HREADYOUT = (state_q != ST_STALL);
   assign IRQ       = en_q & ~empty;

   // Byte-lane enables from the latched size and low address bits (little-endian).
   always_comb begin
      lane = 4'b1111;
      case (size_q)
         2'd0:    lane = 4'b0001 << addr_q[1:0];
         2'd1:    lane = addr_q[1] ? 4'b1100 : 4'b0011;
         default: lane = 4'b1111;
      endcase
      wmask = {{8{lane[3]}}, {8{lane[2]}}, {8{lane[1]}}, {8{lane[0]}}};
   end

   assign wbits    = HWDATA & wmask;
   assign wr_ctrl  = wr & (reg_idx == 3'd0);
   assign wr_stat  = wr & (reg_idx == 3'd1);
   assign wr_sum   = wr & (reg_idx == 3'd4);
   assign wr_wait  = wr & (reg_idx == 3'd5);
   assign clr      = wr_ctrl & wbits[1];
   assign push_req = wr & (reg_idx == 3'd2) & en_q;
   assign pop_req  = rd & (reg_idx == 3'd3) & en_q;
   assign do_push  = push_req & ~full & ~clr;
   assign do_pop   = pop_req & ~empty & ~clr;

   // Next-state and stall counter for the data-phase sequencer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE, ST_RESP: begin
            if (accept) begin
               if (wait_q == '0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_STALL;
                  cnt_d   = wait_q;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_STALL: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = ST_RESP;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sequencer state and latched address-phase controls.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q  <= HADDR[4:0];
            write_q <= HWRITE;
            size_q  <= HSIZE[1:0];
         end
      end
   end

   // Control, status and checksum registers; all commits happen in RESP.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         en_q   <= 1'b0;
         wait_q <= 4'(WAIT_RST);
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
         sum_q  <= '0;
      end else begin
         if (wr_ctrl && lane[0]) en_q <= HWDATA[0];
         if (wr_wait) wait_q <= (wait_q & ~wmask[3:0]) | wbits[3:0];
         // Sticky flags: a same-cycle set wins over write-1-to-clear.
         ovf_q <= (push_req & full & ~clr) | (ovf_q & ~(wr_stat & wbits[10]));
         unf_q <= (pop_req & empty & ~clr) | (unf_q & ~(wr_stat & wbits[11]));
         if (wr_sum)      sum_q <= '0;
         else if (do_pop) sum_q <= sum_q + head;
      end
   end

   // FIFO pointers and occupancy; clr empties the FIFO ahead of any push/pop.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (do_pop && !do_push) count_q <= count_q - 1'b1;
      end
   end

   // FIFO storage.
   always_ff @(posedge HCLK) begin
      if (do_push) mem[wr_ptr_q] <= HWDATA;
   end

   // Read mux over the latched address; driven only in RESP.
   always_comb begin
      rdata = '0;
      case (reg_idx)
         3'd0: rdata = {31'd0, en_q};
         3'd1: begin
            rdata[PTR_W:0] = count_q;
            rdata[8]       = empty;
            rdata[9]       = full;
            rdata[10]      = ovf_q;
            rdata[11]      = unf_q;
         end
         3'd3: rdata = (en_q && !empty) ? head : '0;
         3'd4: rdata = sum_q;
         3'd5: rdata = 32'(wait_q);
         default: rdata = '0;
      endcase
      HRDATA = resp ? rdata : '0;
   end

endmodule
